moesi_snoop_bus: RTL and testbench
==================================

// Module: moesi_snoop_bus
// PURPOSE
//  Shared snooping bus that sits downstream of each cache's MOESI FSM controller and consumes its read/rwitm/invalidate requests.
//  - Arbitrates round-robin among N caches and broadcasts the winning transaction to all other caches.
//  - Collects their shared/abort (intervention) replies and sources data from the owning cache or from memory.
//  - Returns bus_from_state plus the shared flag to the requester, which feeds them back into its FSM.
// PARAMETERS
//  N_CACHES  4   number of attached caches (2..8)
//  ADDR_W    8   block address width
//  DATA_W    16  block data width
//  TIMEOUT   16  memory-wait limit in cycles (used only with MOESI_BUS_TIMEOUT_EN)
// PORTS
//  clock            in   1               single clock; all state updates on the rising edge
//  reset_n          in   1               asynchronous active-low reset
//  req_read         in   N               per-cache read-miss request (level, held until done)
//  req_rwitm        in   N               per-cache read-with-intent-to-modify request
//  req_invalidate   in   N               per-cache upgrade (invalidate) request
//  req_writeback    in   N               per-cache eviction of an M/O block
//  req_addr         in   N*ADDR_W        per-cache address
//  req_wdata        in   N*DATA_W        per-cache writeback data
//  grant            out  N               one-hot owner of the current transaction
//  bus_valid        out  1               broadcast phase active
//  bus_read / bus_rwitm / bus_invalidate  out  1 each  broadcast command (exactly one set when bus_valid)
//  bus_addr         out  ADDR_W          broadcast address
//  bus_src          out  clog2(N)        index of requester; that cache ignores the snoop
//  snoop_shared     in   N               per-cache "I hold a copy" reply
//  snoop_abort      in   N               per-cache intervention (will supply data)
//  snoop_state      in   N*3             responder's pre-transition coherency state
//  snoop_data       in   N*DATA_W        responder's block data
//  mem_req          out  1               memory access request, held until mem_ready
//  mem_we           out  1               1 = writeback, 0 = read
//  mem_addr         out  ADDR_W          memory address
//  mem_wdata        out  DATA_W          memory write data
//  mem_rdata        in   DATA_W          memory read data, valid with mem_ready
//  mem_ready        in   1               memory completion strobe
//  done             out  N               one-cycle completion pulse to the granted cache
//  resp_data        out  DATA_W          block data, valid with done
//  resp_from_state  out  3               FROM_M / FROM_O / FROM_E / FROM_MEM / FROM_NONE
//  resp_shared      out  1               OR of snoop_shared, valid with done
//  bus_error        out  1               timeout flag pulse, valid with done
// BEHAVIOUR
//  Reset
//  - Every output is 0; the round-robin pointer is 0; FSM is in IDLE.
//  - Reset asserted mid-transaction drops mem_req and grant immediately. No done pulse follows.
//  FSM: IDLE -> SNOOP -> (DONE | MEM -> DONE) -> IDLE; writeback goes IDLE -> MEM.
//  IDLE
//  - The winner is the first cache at or after the pointer with any request bit set.
//  - Per-cache priority: writeback > invalidate > rwitm > read.
//  - grant, command, bus_addr and bus_src are registered on the edge that leaves IDLE.
//  SNOOP (1 cycle)
//  - bus_valid = 1; snoop_* sampled at the end of this cycle; grant's own reply bits are masked.
//  - Invalidate: goes to DONE with resp_from_state = FROM_NONE.
//  - Any abort: goes to DONE. The lowest-index aborting cache supplies resp_data.
//  - Its snoop_state maps M->FROM_M (3'b001), O->FROM_O (3'b011), E->FROM_E (3'b100); any other state maps to FROM_MEM.
//  - No abort: goes to MEM (read) with FROM_MEM (3'b101).
//  MEM
//  - mem_req = 1 from the first MEM cycle until mem_ready is sampled high, then DONE.
//  - Read data is captured from mem_rdata.
//  DONE (1 cycle)
//  - done[grant] = 1; grant clears on exit.
//  - Pointer = winner+1 mod N.
//  Latency (from request visible in IDLE)
//  - Intervention / invalidate: done at cycle +2.
//  - Memory read with mem_ready in its first cycle: done at cycle +3.
//  - Writeback with mem_ready in its first cycle: done at cycle +2.
//  Boundaries
//  - A request dropped mid-transaction is ignored; the transaction completes.
//  - New requests are only sampled in IDLE; the bus is back-to-back capable, so IDLE lasts 1 cycle.
//  - resp_shared is 0 for writeback.
// CONFIGURATION
//  MOESI_BUS_TIMEOUT_EN defined
//  - A counter runs in MEM. After TIMEOUT cycles without mem_ready: mem_req drops and DONE follows.
//  - bus_error = 1 with done; resp_data = 0.
//  MOESI_BUS_TIMEOUT_EN undefined
//  - MEM waits indefinitely; bus_error is tied to 0.
// STRUCTURE
//  Shared package moesi_pkg
//  - State encodings INVALID/MODIFIED/SHARED/OWNED/EXCLUSIVE.
//  - FROM_* codes including FROM_NONE = 3'b000.
//  - Bus command enum and FSM state typedef.
//  Sub-module moesi_rr_arbiter
//  - Combinational round-robin pick: request vector + pointer -> one-hot winner.
// TESTING
//  1. Cache1 read, no snoop replies, mem_ready at first MEM cycle -> done[1] at +3, FROM_MEM, resp_shared=0, data=mem_rdata.
//  2. Cache0 rwitm, cache2 abort with state M, data 16'hBEEF -> done[0] at +2, FROM_M, resp_data 16'hBEEF, mem_req never set.
//  3. Cache3 invalidate, cache1 shared=1 -> bus_invalidate one cycle, done[3] at +2, FROM_NONE.
//  4. All four request reads continuously -> grants in order 0,1,2,3,0; no cache starved.
//  5. Cache2 writeback 8'h40/16'h1234 -> mem_req+mem_we with that address/data, no bus_valid, done[2].
//  6. Reset during MEM wait -> mem_req=0 immediately, no done; with MOESI_BUS_TIMEOUT_EN, no mem_ready for 16 cycles -> done + bus_error.

Source files
------------

// File: rtl/moesi_pkg.sv
// Shared MOESI bus types: cache states, response source codes,
// bus commands and the bus FSM state.
package moesi_pkg;

    typedef enum logic [2:0] {
        INVALID   = 3'd0,
        MODIFIED  = 3'd1,
        SHARED    = 3'd2,
        OWNED     = 3'd3,
        EXCLUSIVE = 3'd4
    } cache_state_e;

    localparam logic [2:0] FROM_NONE = 3'b000;
    localparam logic [2:0] FROM_M    = 3'b001;
    localparam logic [2:0] FROM_O    = 3'b011;
    localparam logic [2:0] FROM_E    = 3'b100;
    localparam logic [2:0] FROM_MEM  = 3'b101;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_READ,
        CMD_RWITM,
        CMD_INV,
        CMD_WB
    } bus_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SNOOP,
        S_MEM,
        S_DONE
    } bus_state_e;

    function automatic logic [2:0] from_code(input logic [2:0] st);
        logic [2:0] code;
        code = FROM_MEM;
        if (st == MODIFIED)       code = FROM_M;
        else if (st == OWNED)     code = FROM_O;
        else if (st == EXCLUSIVE) code = FROM_E;
        return code;
    endfunction

endpackage

// File: rtl/moesi_snoop_bus_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module moesi_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/moesi_snoop_bus.sv
// Round-robin MOESI snooping bus with intervention and memory sourcing.
// Optional memory-wait timeout: define MOESI_BUS_TIMEOUT_EN.
module moesi_snoop_bus
    import moesi_pkg::*;
#(
    parameter  int N_CACHES = 4,
    parameter  int ADDR_W   = 8,
    parameter  int DATA_W   = 16,
    parameter  int TIMEOUT  = 16,
    localparam int SRC_W    = $clog2(N_CACHES)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N_CACHES-1:0]          req_read,
    input  logic [N_CACHES-1:0]          req_rwitm,
    input  logic [N_CACHES-1:0]          req_invalidate,
    input  logic [N_CACHES-1:0]          req_writeback,
    input  logic [N_CACHES*ADDR_W-1:0]   req_addr,
    input  logic [N_CACHES*DATA_W-1:0]   req_wdata,
    output logic [N_CACHES-1:0]          grant,
    output logic                         bus_valid,
    output logic                         bus_read,
    output logic                         bus_rwitm,
    output logic                         bus_invalidate,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [SRC_W-1:0]             bus_src,
    input  logic [N_CACHES-1:0]          snoop_shared,
    input  logic [N_CACHES-1:0]          snoop_abort,
    input  logic [N_CACHES*3-1:0]        snoop_state,
    input  logic [N_CACHES*DATA_W-1:0]   snoop_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ready,
    output logic [N_CACHES-1:0]          done,
    output logic [DATA_W-1:0]            resp_data,
    output logic [2:0]                   resp_from_state,
    output logic                         resp_shared,
    output logic                         bus_error
);

    localparam int N = N_CACHES;

    bus_state_e        state_q, state_d;
    bus_cmd_e          cmd_q, win_cmd;
    logic [N-1:0]      grant_q, any_req, win;
    logic [N-1:0]      shared_m, abort_m;
    logic [SRC_W-1:0]  ptr_q, src_q, win_idx, ab_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [2:0]        from_q;
    logic              shared_q, err_q, tmo, any_abort;

    assign any_req   = req_read | req_rwitm | req_invalidate | req_writeback;
    assign shared_m  = snoop_shared & ~grant_q;
    assign abort_m   = snoop_abort & ~grant_q;
    assign any_abort = |abort_m;

    moesi_rr_arbiter #(.N(N), .PW(SRC_W)) u_arb (
        .req (any_req),
        .ptr (ptr_q),
        .gnt (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++)
            if (win[i]) win_idx = SRC_W'(i);
    end

    always_comb begin
        ab_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (abort_m[i]) ab_idx = SRC_W'(i);
    end

    always_comb begin
        win_cmd = CMD_NONE;
        if (req_writeback[win_idx])       win_cmd = CMD_WB;
        else if (req_invalidate[win_idx]) win_cmd = CMD_INV;
        else if (req_rwitm[win_idx])      win_cmd = CMD_RWITM;
        else if (req_read[win_idx])       win_cmd = CMD_READ;
    end

`ifdef MOESI_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    assign tmo = (state_q == S_MEM) && !mem_ready
              && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               cnt_q <= '0;
        else if (state_q == S_MEM)  cnt_q <= cnt_q + 1'b1;
        else                        cnt_q <= '0;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (|any_req)
                    state_d = (win_cmd == CMD_WB) ? S_MEM : S_SNOOP;
            S_SNOOP:
                if (cmd_q == CMD_INV || any_abort) state_d = S_DONE;
                else                               state_d = S_MEM;
            S_MEM:
                if (mem_ready || tmo) state_d = S_DONE;
            S_DONE:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Transaction context is latched once, so dropped requests cannot abort it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= '0;
            cmd_q    <= CMD_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            src_q    <= '0;
            ptr_q    <= '0;
            rdata_q  <= '0;
            from_q   <= FROM_NONE;
            shared_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (|any_req) begin
                    grant_q  <= win;
                    cmd_q    <= win_cmd;
                    addr_q   <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_q  <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                    src_q    <= win_idx;
                    rdata_q  <= '0;
                    from_q   <= FROM_NONE;
                    shared_q <= 1'b0;
                    err_q    <= 1'b0;
                end
                S_SNOOP: begin
                    shared_q <= |shared_m;
                    if (cmd_q == CMD_INV) begin
                        from_q <= FROM_NONE;
                    end else if (any_abort) begin
                        rdata_q <= snoop_data[int'(ab_idx)*DATA_W +: DATA_W];
                        from_q  <= from_code(snoop_state[int'(ab_idx)*3 +: 3]);
                    end else begin
                        from_q <= FROM_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        rdata_q <= (cmd_q == CMD_WB) ? '0 : mem_rdata;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    grant_q <= '0;
                    ptr_q   <= SRC_W'((int'(src_q) + 1) % N);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant           = grant_q;
        bus_valid       = 1'b0;
        bus_read        = 1'b0;
        bus_rwitm       = 1'b0;
        bus_invalidate  = 1'b0;
        bus_addr        = addr_q;
        bus_src         = src_q;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        done            = '0;
        resp_data       = '0;
        resp_from_state = FROM_NONE;
        resp_shared     = 1'b0;
        bus_error       = 1'b0;
        unique case (state_q)
            S_SNOOP: begin
                bus_valid      = 1'b1;
                bus_read       = (cmd_q == CMD_READ);
                bus_rwitm      = (cmd_q == CMD_RWITM);
                bus_invalidate = (cmd_q == CMD_INV);
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (cmd_q == CMD_WB);
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_DONE: begin
                done            = grant_q;
                resp_data       = rdata_q;
                resp_from_state = from_q;
                resp_shared     = shared_q;
                bus_error       = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_moesi_snoop_bus.sv
// Directed self-checking bench for moesi_snoop_bus.
// Timeout check runs only when MOESI_BUS_TIMEOUT_EN is defined.
module tb_moesi_snoop_bus;
    import moesi_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_read, req_rwitm, req_invalidate, req_writeback;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant;
    logic            bus_valid, bus_read, bus_rwitm, bus_invalidate;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      bus_src;
    logic [N-1:0]    snoop_shared, snoop_abort;
    logic [N*3-1:0]  snoop_state;
    logic [N*DW-1:0] snoop_data;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_ready;
    logic [N-1:0]    done;
    logic [DW-1:0]   resp_data;
    logic [2:0]      resp_from_state;
    logic            resp_shared, bus_error;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    moesi_snoop_bus dut (
        .clock(clock), .reset_n(reset_n),
        .req_read(req_read), .req_rwitm(req_rwitm),
        .req_invalidate(req_invalidate), .req_writeback(req_writeback),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .bus_valid(bus_valid), .bus_read(bus_read),
        .bus_rwitm(bus_rwitm), .bus_invalidate(bus_invalidate),
        .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_shared(snoop_shared), .snoop_abort(snoop_abort),
        .snoop_state(snoop_state), .snoop_data(snoop_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .done(done), .resp_data(resp_data),
        .resp_from_state(resp_from_state), .resp_shared(resp_shared),
        .bus_error(bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_all();
        req_read = '0; req_rwitm = '0; req_invalidate = '0;
        req_writeback = '0; snoop_shared = '0; snoop_abort = '0;
        snoop_state = '0; snoop_data = '0; mem_ready = 1'b0;
    endtask

    initial begin
        clear_all();
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        reset_n = 1'b0;
        step(); step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'h0);
        chk("rst_memreq", 32'(mem_req), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        step();

        // 1: cache1 read served by memory
        req_read[1] = 1'b1;
        req_addr[1*AW +: AW] = 8'h11;
        #1 chk("t1_idle_grant", 32'(grant), 32'h0);
        step();
        chk("t1_valid", 32'(bus_valid), 32'h1);
        chk("t1_read", 32'(bus_read), 32'h1);
        chk("t1_grant", 32'(grant), 32'h2);
        chk("t1_addr", 32'(bus_addr), 32'h11);
        chk("t1_src", 32'(bus_src), 32'h1);
        step();
        chk("t1_memreq", 32'(mem_req), 32'h1);
        chk("t1_memwe", 32'(mem_we), 32'h0);
        chk("t1_memaddr", 32'(mem_addr), 32'h11);
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        step();
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_from", 32'(resp_from_state), 32'(FROM_MEM));
        chk("t1_shared", 32'(resp_shared), 32'h0);
        chk("t1_data", 32'(resp_data), 32'hCAFE);
        chk("t1_err", 32'(bus_error), 32'h0);
        clear_all();
        step();

        // 2: cache0 rwitm, cache2 intervenes in M; own abort masked
        req_rwitm[0] = 1'b1;
        req_addr[0 +: AW] = 8'h22;
        step();
        chk("t2_rwitm", 32'(bus_rwitm), 32'h1);
        chk("t2_grant", 32'(grant), 32'h1);
        snoop_abort = 4'b0101;
        snoop_state[2*3 +: 3] = MODIFIED;
        snoop_data[2*DW +: DW] = 16'hBEEF;
        snoop_data[0 +: DW] = 16'hDEAD;
        chk("t2_nomem_snoop", 32'(mem_req), 32'h0);
        step();
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_from", 32'(resp_from_state), 32'(FROM_M));
        chk("t2_data", 32'(resp_data), 32'hBEEF);
        chk("t2_nomem_done", 32'(mem_req), 32'h0);
        clear_all();
        step();

        // 3: cache3 invalidate with cache1 sharing
        req_invalidate[3] = 1'b1;
        req_addr[3*AW +: AW] = 8'h33;
        step();
        chk("t3_inv", 32'(bus_invalidate), 32'h1);
        chk("t3_read", 32'(bus_read), 32'h0);
        chk("t3_src", 32'(bus_src), 32'h3);
        snoop_shared[1] = 1'b1;
        step();
        chk("t3_done", 32'(done), 32'h8);
        chk("t3_from", 32'(resp_from_state), 32'(FROM_NONE));
        chk("t3_shared", 32'(resp_shared), 32'h1);
        chk("t3_valid", 32'(bus_valid), 32'h0);
        clear_all();
        step();

        // 4: all caches read continuously; rotate 0,1,2,3,0
        req_read = 4'b1111;
        mem_ready = 1'b1;
        mem_rdata = 16'h0A0A;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t4_grant%0d", k), 32'(grant), 32'(1 << (k % 4)));
            step();
            step();
            chk($sformatf("t4_done%0d", k), 32'(done), 32'(1 << (k % 4)));
            step();
        end
        clear_all();

        // 5: cache2 writeback goes straight to memory
        req_writeback[2] = 1'b1;
        req_addr[2*AW +: AW] = 8'h40;
        req_wdata[2*DW +: DW] = 16'h1234;
        snoop_shared = 4'b1111;
        step();
        chk("t5_valid", 32'(bus_valid), 32'h0);
        chk("t5_memreq", 32'(mem_req), 32'h1);
        chk("t5_memwe", 32'(mem_we), 32'h1);
        chk("t5_memaddr", 32'(mem_addr), 32'h40);
        chk("t5_wdata", 32'(mem_wdata), 32'h1234);
        chk("t5_grant", 32'(grant), 32'h4);
        mem_ready = 1'b1;
        step();
        chk("t5_done", 32'(done), 32'h4);
        chk("t5_shared", 32'(resp_shared), 32'h0);
        clear_all();
        step();

        // 6: reset while waiting on memory
        req_read[1] = 1'b1;
        req_addr[1*AW +: AW] = 8'h55;
        step();
        step();
        chk("t6_memreq", 32'(mem_req), 32'h1);
        step();
        chk("t6_memwait", 32'(mem_req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_memreq", 32'(mem_req), 32'h0);
        chk("t6_rst_grant", 32'(grant), 32'h0);
        step();
        chk("t6_nodone_a", 32'(done), 32'h0);
        step();
        chk("t6_nodone_b", 32'(done), 32'h0);
        clear_all();
        reset_n = 1'b1;
        step();

`ifdef MOESI_BUS_TIMEOUT_EN
        req_read[0] = 1'b1;
        req_addr[0 +: AW] = 8'h66;
        step();
        step();
        chk("t7_memreq", 32'(mem_req), 32'h1);
        for (int k = 0; k < 15; k++) step();
        chk("t7_memreq_last", 32'(mem_req), 32'h1);
        step();
        chk("t7_done", 32'(done), 32'h1);
        chk("t7_err", 32'(bus_error), 32'h1);
        chk("t7_data", 32'(resp_data), 32'h0);
        chk("t7_memreq_off", 32'(mem_req), 32'h0);
        clear_all();
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
